io_port_responder: RTL and testbench
====================================

Name: io_port_responder

Overview:
- Device-side endpoint for one Datapath I/O port.
- Answers the Datapath's io_rden / io_wren strobes with read data and empty/full (EF) flags, backed by two small FIFOs.
- Receive FIFO: external valid/ready source → Datapath reads. Transmit FIFO: Datapath writes → external valid/ready sink.
- Instantiated once per port; instances are concatenated to form the io_read_data / io_read_EF / io_write_EF buses.

Parameters:
- WORD_WIDTH, 36, width of one I/O word.
- FIFO_DEPTH, 4, entries per FIFO; must be a power of 2 and at least 2.
- FIFO_ADDR_WIDTH, 2, log2(FIFO_DEPTH).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- io_rden  input  1  Datapath read strobe; pops the receive FIFO.
- io_read_data  output  WORD_WIDTH  receive FIFO head word.
- io_read_EF  output  1  1 = receive FIFO holds at least one word.
- io_wren  input  1  Datapath write strobe; pushes io_write_data.
- io_write_data  input  WORD_WIDTH  word written by the Datapath.
- io_write_EF  output  1  1 = transmit FIFO has at least one free slot.
- in_valid  input  1  external source offers in_data.
- in_ready  output  1  receive FIFO can accept a word.
- in_data  input  WORD_WIDTH  external source word.
- out_valid  output  1  transmit FIFO head is available.
- out_ready  input  1  external sink accepts the head word.
- out_data  output  WORD_WIDTH  transmit FIFO head word.
- underflow  output  1  sticky: io_rden seen while receive FIFO empty.
- overflow  output  1  sticky: io_wren seen while transmit FIFO full.

Behaviour:
- Reset (asynchronous):
  - Both FIFOs empty; counts and pointers 0.
  - io_read_EF=0, io_write_EF=1, in_ready=1, out_valid=0, underflow=0, overflow=0.
  - io_read_data and out_data read 0.
- FIFO structure (both FIFOs):
  - Read pointer, write pointer, occupancy count of FIFO_ADDR_WIDTH+1 bits.
  - Pointers wrap modulo FIFO_DEPTH.
- Flag timing:
  - Flags and ready/valid are decoded from the registered count only: empty = count==0, full = count==FIFO_DEPTH.
  - No combinational path from any input to any flag.
  - io_read_EF = out_valid-style (rx not empty); io_write_EF = in_ready-style (tx not full).
- Data timing (show-ahead):
  - io_read_data and out_data are driven from storage at the read pointer.
  - io_read_data = 0 when the receive FIFO is empty; out_data = 0 when the transmit FIFO is empty.
- Receive push: in_valid & in_ready. Word stored; write pointer +1; visible on io_read_EF / io_read_data the next cycle (1-cycle latency).
- Receive pop: io_rden & io_read_EF. Read pointer +1.
- Receive push and pop in the same cycle: count unchanged, both pointers advance. Allowed whenever both qualify.
- Receive push at full: in_ready=0, so not accepted even if a pop happens the same cycle; no bypass.
- Transmit side mirrors the receive side:
  - Push on io_wren & io_write_EF; pop on out_valid & out_ready.
  - Same-cycle push/pop allowed; push at full not accepted.
- Protocol violations:
  - io_rden with io_read_EF=0: no state change except underflow←1.
  - io_wren with io_write_EF=0: word dropped, overflow←1.
  - Sticky flags clear only on reset.
- Reset asserted mid-operation: all contents discarded at once and outputs return to reset values. Inputs during reset are ignored.
- External valid/ready rules:
  - The external source may drop in_valid at any time.
  - Once out_valid=1, it stays high and out_data stays stable until out_ready.

Test Plan:
- Reset, then 2 pushes via in_valid (0x1, 0x2) → io_read_EF=1 the cycle after the first push, io_read_data=0x1; io_rden pops give 0x1 then 0x2; io_read_EF=0 after the second pop.
- 4 pushes into the receive FIFO with no pops → in_ready=0 after the 4th; a 5th in_valid (0x5) is not accepted; pops return 0x1..0x4 in order across pointer wrap.
- io_wren with write_data 0xA, 0xB, 0xC, 0xD; out_ready=0 → io_write_EF=0 after the 4th; extra io_wren (0xE) sets overflow=1; out_ready=1 drains 0xA..0xD; out_valid=0 afterwards.
- Receive FIFO holding 2 words, push and pop in the same cycle for 6 cycles → count stays 2; data order preserved; underflow=0.
- io_rden on an empty receive FIFO → underflow=1, pointers unchanged; a following push of 0x7 is read back as 0x7.
- Transmit FIFO with 3 words, assert reset for 1 cycle mid-stream → out_valid=0, io_write_EF=1, overflow=0 immediately (asynchronous); next write 0x9 appears on out_data one cycle later.

Source files
------------

// File: rtl/io_port_responder.sv
//------------------------------------------------------------------------------
// io_port_responder
//
// Device-side endpoint for one Datapath I/O port. The Datapath reads words
// that an external valid/ready source has delivered into a receive FIFO, and
// writes words into a transmit FIFO that an external valid/ready sink drains.
// Both FIFOs are show-ahead: the head word is always presented on the data
// output, and reads as zero while the FIFO is empty.
//
// Ports (io_port_responder):
//   clock          single clock, rising edge
//   reset          asynchronous, active-high, clears all state
//   io_rden        Datapath read strobe, pops the receive FIFO
//   io_read_data   receive FIFO head word (0 when empty)
//   io_read_EF     1 = receive FIFO holds at least one word
//   io_wren        Datapath write strobe, pushes io_write_data
//   io_write_data  word written by the Datapath
//   io_write_EF    1 = transmit FIFO has at least one free slot
//   in_valid       external source offers in_data
//   in_ready       receive FIFO can accept a word
//   in_data        external source word
//   out_valid      transmit FIFO head is available
//   out_ready      external sink accepts the head word
//   out_data       transmit FIFO head word (0 when empty)
//   underflow      sticky: io_rden seen while receive FIFO empty
//   overflow       sticky: io_wren seen while transmit FIFO full
//
// FIFO_DEPTH must be a power of two, at least 2, and equal 2**FIFO_ADDR_WIDTH
// so that the pointers wrap naturally.
//------------------------------------------------------------------------------

//------------------------------------------------------------------------------
// io_port_fifo
//
// Synchronous show-ahead FIFO used for both directions of the port.
// Requests that cannot be honoured (push when full, pop when empty) are
// ignored here; the caller decides whether they are protocol violations.
//
// Ports (io_port_fifo):
//   clock, reset   as above
//   i_push/i_data  push request and word
//   i_pop          pop request
//   o_data         head word, 0 when empty
//   o_empty        occupancy count is zero
//   o_full         occupancy count equals DEPTH
//------------------------------------------------------------------------------
module io_port_fifo #(
   parameter int WIDTH      = 36,
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_full
);

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_count;

   logic w_push;
   logic w_pop;

   // Flags come from the registered count only, so no input reaches a flag
   // combinationally. A push at full is refused even if a pop happens in the
   // same cycle: there is no bypass.
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (ADDR_WIDTH+1)'(DEPTH));

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop  & ~o_empty;

   // NOTE: state registers use non-blocking assignments so every register in
   // the design samples pre-edge values, independent of process ordering.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         end
         // Simultaneous push and pop leaves the count unchanged.
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
            2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; stale words are never visible
   // because the head word is forced to zero while the count is zero.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

//------------------------------------------------------------------------------
// io_port_responder top
//------------------------------------------------------------------------------
module io_port_responder #(
   parameter int WORD_WIDTH      = 36,
   parameter int FIFO_DEPTH      = 4,
   parameter int FIFO_ADDR_WIDTH = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   // Datapath read side (receive FIFO)
   input  logic                  io_rden,
   output logic [WORD_WIDTH-1:0] io_read_data,
   output logic                  io_read_EF,
   // Datapath write side (transmit FIFO)
   input  logic                  io_wren,
   input  logic [WORD_WIDTH-1:0] io_write_data,
   output logic                  io_write_EF,
   // External source
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_WIDTH-1:0] in_data,
   // External sink
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_WIDTH-1:0] out_data,
   // Sticky protocol-violation flags
   output logic                  underflow,
   output logic                  overflow
);

   logic w_rx_empty;
   logic w_rx_full;
   logic w_tx_empty;
   logic w_tx_full;

   logic r_underflow;
   logic r_overflow;

   // Receive path: external source pushes, Datapath pops.
   io_port_fifo #(
      .WIDTH      (WORD_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_rx_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (in_valid),
      .i_data  (in_data),
      .i_pop   (io_rden),
      .o_data  (io_read_data),
      .o_empty (w_rx_empty),
      .o_full  (w_rx_full)
   );

   // Transmit path: Datapath pushes, external sink pops. Because the head
   // only moves on out_ready, out_valid/out_data hold until accepted.
   io_port_fifo #(
      .WIDTH      (WORD_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_tx_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (io_wren),
      .i_data  (io_write_data),
      .i_pop   (out_ready),
      .o_data  (out_data),
      .o_empty (w_tx_empty),
      .o_full  (w_tx_full)
   );

   assign io_read_EF  = ~w_rx_empty;
   assign in_ready    = ~w_rx_full;
   assign io_write_EF = ~w_tx_full;
   assign out_valid   = ~w_tx_empty;

   // Violations only set the sticky flags; the FIFOs already ignore the
   // offending request, so no other state changes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (io_rden && w_rx_empty) begin
            r_underflow <= 1'b1;
         end
         if (io_wren && w_tx_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign underflow = r_underflow;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_io_port_responder.sv
//------------------------------------------------------------------------------
// tb_io_port_responder
//
// Directed stimulus with a scoreboard: the stimulus process pushes the word
// it expects to come out of each FIFO; two monitor processes pop and compare
// whenever a word is consumed (io_rden & io_read_EF, out_valid & out_ready).
// Flags are checked directly against hand-computed values. Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling edge
// or 1 time unit after the rising edge.
//------------------------------------------------------------------------------
module tb_io_port_responder;

   localparam int W = 36;

   logic         clock = 1'b0;
   logic         reset;
   logic         io_rden;
   logic [W-1:0] io_read_data;
   logic         io_read_EF;
   logic         io_wren;
   logic [W-1:0] io_write_data;
   logic         io_write_EF;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         underflow;
   logic         overflow;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] rx_q[$];
   logic [W-1:0] tx_q[$];

   io_port_responder #(
      .WORD_WIDTH      (W),
      .FIFO_DEPTH      (4),
      .FIFO_ADDR_WIDTH (2)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .io_rden       (io_rden),
      .io_read_data  (io_read_data),
      .io_read_EF    (io_read_EF),
      .io_wren       (io_wren),
      .io_write_data (io_write_data),
      .io_write_EF   (io_write_EF),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .underflow     (underflow),
      .overflow      (overflow)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Receive-side monitor: a word is consumed when io_rden meets io_read_EF.
   always @(negedge clock) begin
      if (!reset && io_rden && io_read_EF) begin
         if (rx_q.size() == 0) begin
            check("rx_unexpected_pop", 64'(io_read_data), 64'hDEAD);
         end else begin
            check("rx_data", 64'(io_read_data), 64'(rx_q.pop_front()));
         end
      end
   end

   // Transmit-side monitor: a word is consumed when out_valid meets out_ready.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (tx_q.size() == 0) begin
            check("tx_unexpected_pop", 64'(out_data), 64'hDEAD);
         end else begin
            check("tx_data", 64'(out_data), 64'(tx_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset         = 1'b1;
      io_rden       = 1'b0;
      io_wren       = 1'b0;
      io_write_data = '0;
      in_valid      = 1'b0;
      in_data       = '0;
      out_ready     = 1'b0;
      step();
      step();
      reset = 1'b0;
      step();

      // Reset values
      check("rst_read_EF",   64'(io_read_EF),   64'd0);
      check("rst_write_EF",  64'(io_write_EF),  64'd1);
      check("rst_in_ready",  64'(in_ready),     64'd1);
      check("rst_out_valid", 64'(out_valid),    64'd0);
      check("rst_underflow", 64'(underflow),    64'd0);
      check("rst_overflow",  64'(overflow),     64'd0);
      check("rst_read_data", 64'(io_read_data), 64'd0);
      check("rst_out_data",  64'(out_data),     64'd0);

      // Two pushes, then two pops
      in_valid = 1'b1;
      in_data  = 36'h1;
      rx_q.push_back(36'h1);
      step();
      check("t1_EF_after_push", 64'(io_read_EF),   64'd1);
      check("t1_head",          64'(io_read_data), 64'h1);
      in_data = 36'h2;
      rx_q.push_back(36'h2);
      step();
      in_valid = 1'b0;
      io_rden  = 1'b1;
      step();
      step();
      io_rden = 1'b0;
      check("t1_EF_empty", 64'(io_read_EF), 64'd0);

      // Fill the receive FIFO; a fifth word is refused; drain across wrap
      in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_data = W'(i);
         rx_q.push_back(W'(i));
         step();
      end
      check("t2_in_ready_full", 64'(in_ready), 64'd0);
      in_data = 36'h5;
      step();
      in_valid = 1'b0;
      check("t2_in_ready_still_full", 64'(in_ready),     64'd0);
      check("t2_head_after_refused",  64'(io_read_data), 64'h1);
      io_rden = 1'b1;
      repeat (4) step();
      io_rden = 1'b0;
      check("t2_EF_empty",  64'(io_read_EF), 64'd0);
      check("t2_underflow", 64'(underflow),  64'd0);

      // Transmit fill with sink stalled, overflow, then drain
      io_wren = 1'b1;
      for (int i = 0; i < 4; i++) begin
         io_write_data = 36'hA + W'(i);
         tx_q.push_back(36'hA + W'(i));
         step();
      end
      check("t3_write_EF_full", 64'(io_write_EF), 64'd0);
      check("t3_out_valid",     64'(out_valid),   64'd1);
      check("t3_out_head",      64'(out_data),    64'hA);
      io_write_data = 36'hE;
      step();
      io_wren = 1'b0;
      check("t3_overflow",     64'(overflow), 64'd1);
      check("t3_head_stable",  64'(out_data), 64'hA);
      out_ready = 1'b1;
      repeat (4) step();
      out_ready = 1'b0;
      check("t3_out_valid_empty", 64'(out_valid),   64'd0);
      check("t3_out_data_zero",   64'(out_data),    64'd0);
      check("t3_write_EF_free",   64'(io_write_EF), 64'd1);

      // Receive FIFO at 2 words, push+pop every cycle for 6 cycles
      in_valid = 1'b1;
      in_data  = 36'h11;
      rx_q.push_back(36'h11);
      step();
      in_data = 36'h12;
      rx_q.push_back(36'h12);
      step();
      io_rden = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = 36'h20 + W'(i);
         rx_q.push_back(36'h20 + W'(i));
         step();
      end
      in_valid = 1'b0;
      check("t4_in_ready", 64'(in_ready),   64'd1);
      check("t4_EF",       64'(io_read_EF), 64'd1);
      // Count held at 2: exactly two more pops empty the FIFO
      step();
      step();
      io_rden = 1'b0;
      check("t4_EF_empty_after_2", 64'(io_read_EF), 64'd0);
      check("t4_underflow",        64'(underflow),  64'd0);

      // Read on empty: underflow, no pointer motion
      io_rden = 1'b1;
      step();
      io_rden = 1'b0;
      check("t5_underflow", 64'(underflow),  64'd1);
      check("t5_EF",        64'(io_read_EF), 64'd0);
      in_valid = 1'b1;
      in_data  = 36'h7;
      rx_q.push_back(36'h7);
      step();
      in_valid = 1'b0;
      check("t5_head", 64'(io_read_data), 64'h7);
      io_rden = 1'b1;
      step();
      io_rden = 1'b0;
      check("t5_EF_empty", 64'(io_read_EF), 64'd0);

      // Reset mid-stream with 3 words in the transmit FIFO
      io_wren = 1'b1;
      for (int i = 0; i < 3; i++) begin
         io_write_data = 36'h31 + W'(i);
         step();
      end
      io_wren = 1'b0;
      check("t6_out_valid_pre", 64'(out_valid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      tx_q.delete();
      rx_q.delete();
      check("t6_out_valid_async", 64'(out_valid),   64'd0);
      check("t6_write_EF_async",  64'(io_write_EF), 64'd1);
      check("t6_overflow_async",  64'(overflow),    64'd0);
      check("t6_underflow_async", 64'(underflow),   64'd0);
      check("t6_out_data_async",  64'(out_data),    64'd0);
      step();
      reset = 1'b0;
      io_wren       = 1'b1;
      io_write_data = 36'h9;
      tx_q.push_back(36'h9);
      step();
      io_wren = 1'b0;
      check("t6_out_valid_new", 64'(out_valid), 64'd1);
      check("t6_out_data_new",  64'(out_data),  64'h9);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("t6_out_valid_end", 64'(out_valid), 64'd0);

      // Every expected word must have been consumed
      check("rx_queue_drained", 64'(rx_q.size()), 64'd0);
      check("tx_queue_drained", 64'(tx_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
